// File: rtl/div_control_sequencer.sv
// Control-step sequencer for one instruction fetch followed by a DIV execute.
// Drives the Datapath bus-drive/load strobes, one-hot GPR select and ALU op.
module div_control_sequencer #(
  parameter logic [4:0]  DIV_OP     = 5'b01111,
  parameter int unsigned DIV_CYCLES = 4
) (
  input  logic        clk,
  input  logic        Clear,
  input  logic        start,
  input  logic        mem_ready,
  input  logic [31:0] IR_q,
  output logic        PCout,
  output logic        Zlowout,
  output logic        Zhiout,
  output logic        MDRout,
  output logic        MARin,
  output logic        PCin,
  output logic        IncPC,
  output logic        Read,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        LOin,
  output logic        HIin,
  output logic [15:0] Rout,
  output logic [4:0]  IRout,
  output logic        busy,
  output logic        done,
  output logic        illegal
);

  localparam int unsigned CNT_W    = 4;
  localparam int unsigned REG_W    = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_DONE = 4'd8,
    S_ILL  = 4'd9
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [REG_W-1:0]   rb_q, rb_d;

  logic               op_legal_c;
  logic [REG_W-1:0]   ra_c;
  logic               unused_ir_bits;

  assign op_legal_c     = (IR_q[31:27] == DIV_OP);
  assign ra_c           = IR_q[26:23];
  assign unused_ir_bits = ^IR_q[18:0];

  // State, divide wait counter and latched Rb field
  always_ff @(posedge clk) begin
    if (Clear) begin
      state_q <= S_IDLE;
      count_q <= '0;
      rb_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rb_q    <= rb_d;
    end
  end

  // Next-state logic; count is cleared outside T4 so it always enters at 0
  always_comb begin
    state_d = state_q;
    count_d = '0;
    rb_d    = rb_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   if (mem_ready) state_d = S_T2;
      S_T2:   state_d = S_T3;
      S_T3: begin
        if (op_legal_c) begin
          state_d = S_T4;
          rb_d    = IR_q[22:19];
        end else begin
          state_d = S_ILL;
        end
      end
      S_T4: begin
        if (count_q == CNT_LAST) begin
          state_d = S_T5;
          count_d = count_q;
        end else if (count_q < CNT_LAST) begin
          count_d = count_q + CNT_W'(1);
        end else begin
          count_d = count_q;
        end
      end
      S_T5:   state_d = S_T6;
      S_T6:   state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      S_ILL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode; PCin is qualified by mem_ready so PC loads once per fetch,
  // and the T3 select/Yin depend on the freshly loaded IR opcode and Ra
  always_comb begin
    PCout   = 1'b0;
    Zlowout = 1'b0;
    Zhiout  = 1'b0;
    MDRout  = 1'b0;
    MARin   = 1'b0;
    PCin    = 1'b0;
    IncPC   = 1'b0;
    Read    = 1'b0;
    MDRin   = 1'b0;
    IRin    = 1'b0;
    Yin     = 1'b0;
    Zin     = 1'b0;
    LOin    = 1'b0;
    HIin    = 1'b0;
    Rout    = '0;
    IRout   = '0;
    busy    = (state_q != S_IDLE);
    done    = 1'b0;
    illegal = 1'b0;
    unique case (state_q)
      S_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      S_T1: begin
        Zlowout = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        PCin    = mem_ready;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        if (op_legal_c) begin
          Rout = 16'(1) << ra_c;
          Yin  = 1'b1;
        end
      end
      S_T4: begin
        Rout  = 16'(1) << rb_q;
        IRout = DIV_OP;
        Zin   = (count_q == CNT_LAST);
      end
      S_T5: begin
        Zlowout = 1'b1;
        LOin    = 1'b1;
      end
      S_T6: begin
        Zhiout = 1'b1;
        HIin   = 1'b1;
      end
      S_DONE: done    = 1'b1;
      S_ILL:  illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_div_control_sequencer.sv
// Table-driven bench: each row is one clock cycle of inputs plus the outputs
// expected during that same cycle.
module tb_div_control_sequencer;

  logic        clk = 1'b0;
  logic        Clear, start, mem_ready;
  logic [31:0] IR_q;
  logic        PCout, Zlowout, Zhiout, MDRout, MARin, PCin, IncPC, Read, MDRin;
  logic        IRin, Yin, Zin, LOin, HIin, busy, done, illegal;
  logic [15:0] Rout;
  logic [4:0]  IRout;

  always #5 clk = ~clk;

  div_control_sequencer dut (
    .clk(clk), .Clear(Clear), .start(start), .mem_ready(mem_ready), .IR_q(IR_q),
    .PCout(PCout), .Zlowout(Zlowout), .Zhiout(Zhiout), .MDRout(MDRout),
    .MARin(MARin), .PCin(PCin), .IncPC(IncPC), .Read(Read), .MDRin(MDRin),
    .IRin(IRin), .Yin(Yin), .Zin(Zin), .LOin(LOin), .HIin(HIin),
    .Rout(Rout), .IRout(IRout), .busy(busy), .done(done), .illegal(illegal)
  );

  // Strobe vector bit positions
  localparam logic [16:0] B_PCOUT = 17'h10000;
  localparam logic [16:0] B_ZLO   = 17'h08000;
  localparam logic [16:0] B_ZHI   = 17'h04000;
  localparam logic [16:0] B_MDRO  = 17'h02000;
  localparam logic [16:0] B_MARIN = 17'h01000;
  localparam logic [16:0] B_PCIN  = 17'h00800;
  localparam logic [16:0] B_INCPC = 17'h00400;
  localparam logic [16:0] B_READ  = 17'h00200;
  localparam logic [16:0] B_MDRIN = 17'h00100;
  localparam logic [16:0] B_IRIN  = 17'h00080;
  localparam logic [16:0] B_YIN   = 17'h00040;
  localparam logic [16:0] B_ZIN   = 17'h00020;
  localparam logic [16:0] B_LOIN  = 17'h00010;
  localparam logic [16:0] B_HIIN  = 17'h00008;
  localparam logic [16:0] B_BUSY  = 17'h00004;
  localparam logic [16:0] B_DONE  = 17'h00002;
  localparam logic [16:0] B_ILL   = 17'h00001;

  localparam logic [16:0] E_IDLE  = 17'h0;
  localparam logic [16:0] E_T0    = B_PCOUT | B_MARIN | B_INCPC | B_ZIN | B_BUSY;
  localparam logic [16:0] E_T1W   = B_ZLO | B_READ | B_MDRIN | B_BUSY;
  localparam logic [16:0] E_T1R   = E_T1W | B_PCIN;
  localparam logic [16:0] E_T2    = B_MDRO | B_IRIN | B_BUSY;
  localparam logic [16:0] E_T3    = B_YIN | B_BUSY;
  localparam logic [16:0] E_T3BAD = B_BUSY;
  localparam logic [16:0] E_T4    = B_BUSY;
  localparam logic [16:0] E_T4Z   = B_ZIN | B_BUSY;
  localparam logic [16:0] E_T5    = B_ZLO | B_LOIN | B_BUSY;
  localparam logic [16:0] E_T6    = B_ZHI | B_HIIN | B_BUSY;
  localparam logic [16:0] E_DONE  = B_DONE | B_BUSY;
  localparam logic [16:0] E_ILLS  = B_ILL | B_BUSY;

  localparam logic [4:0]  OP_DIV  = 5'b01111;

  typedef struct {
    logic        clr;
    logic        st;
    logic        rdy;
    logic [31:0] ir;
    logic [16:0] strb;
    logic [15:0] rout;
    logic [4:0]  irout;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  logic [31:0] ir_a, ir_b, ir_bad;

  task automatic add(input logic c, input logic s, input logic r, input logic [31:0] ir,
                     input logic [16:0] e, input logic [15:0] ro, input logic [4:0] io);
    vec_t v;
    v.clr = c; v.st = s; v.rdy = r; v.ir = ir; v.strb = e; v.rout = ro; v.irout = io;
    tbl.push_back(v);
  endtask

  function automatic logic [16:0] strobes();
    return {PCout, Zlowout, Zhiout, MDRout, MARin, PCin, IncPC, Read, MDRin,
            IRin, Yin, Zin, LOin, HIin, busy, done, illegal};
  endfunction

  initial begin
    ir_a   = 32'h7888_0000;                         // DIV, Ra=1, Rb=1
    ir_b   = {5'b01111, 4'd3, 4'd5, 19'd0};         // DIV, Ra=3, Rb=5
    ir_bad = {5'b00011, 4'd2, 4'd4, 19'd0};         // not DIV

    // reset state, then Clear overriding start
    add(0, 0, 1, ir_a, E_IDLE, 16'h0, 5'h0);
    add(1, 1, 1, ir_a, E_IDLE, 16'h0, 5'h0);
    add(0, 0, 1, ir_a, E_IDLE, 16'h0, 5'h0);

    // basic DIV with mem_ready high; stray start in T5 must not queue
    add(0, 1, 1, ir_a, E_IDLE, 16'h0, 5'h0);
    add(0, 0, 1, ir_a, E_T0,   16'h0, 5'h0);
    add(0, 0, 1, ir_a, E_T1R,  16'h0, 5'h0);
    add(0, 0, 1, ir_a, E_T2,   16'h0, 5'h0);
    add(0, 0, 1, ir_a, E_T3,   16'h0002, 5'h0);
    for (int i = 0; i < 3; i++) add(0, 0, 1, ir_a, E_T4, 16'h0002, OP_DIV);
    add(0, 0, 1, ir_a, E_T4Z,  16'h0002, OP_DIV);
    add(0, 1, 1, ir_a, E_T5,   16'h0, 5'h0);
    add(0, 0, 1, ir_a, E_T6,   16'h0, 5'h0);
    add(0, 0, 1, ir_a, E_DONE, 16'h0, 5'h0);
    add(0, 0, 1, ir_a, E_IDLE, 16'h0, 5'h0);
    add(0, 0, 1, ir_a, E_IDLE, 16'h0, 5'h0);

    // three wait cycles in T1, distinct Ra/Rb; done at cycle 14
    add(0, 1, 1, ir_b, E_IDLE, 16'h0, 5'h0);
    add(0, 0, 1, ir_b, E_T0,   16'h0, 5'h0);
    for (int i = 0; i < 3; i++) add(0, 0, 0, ir_b, E_T1W, 16'h0, 5'h0);
    add(0, 0, 1, ir_b, E_T1R,  16'h0, 5'h0);
    add(0, 0, 1, ir_b, E_T2,   16'h0, 5'h0);
    add(0, 0, 1, ir_b, E_T3,   16'h0008, 5'h0);
    for (int i = 0; i < 3; i++) add(0, 0, 1, ir_b, E_T4, 16'h0020, OP_DIV);
    add(0, 0, 1, ir_b, E_T4Z,  16'h0020, OP_DIV);
    add(0, 0, 1, ir_b, E_T5,   16'h0, 5'h0);
    add(0, 0, 1, ir_b, E_T6,   16'h0, 5'h0);
    add(0, 0, 1, ir_b, E_DONE, 16'h0, 5'h0);
    add(0, 0, 1, ir_b, E_IDLE, 16'h0, 5'h0);

    // illegal opcode
    add(0, 1, 1, ir_bad, E_IDLE,  16'h0, 5'h0);
    add(0, 0, 1, ir_bad, E_T0,    16'h0, 5'h0);
    add(0, 0, 1, ir_bad, E_T1R,   16'h0, 5'h0);
    add(0, 0, 1, ir_bad, E_T2,    16'h0, 5'h0);
    add(0, 0, 1, ir_bad, E_T3BAD, 16'h0, 5'h0);
    add(0, 0, 1, ir_bad, E_ILLS,  16'h0, 5'h0);
    add(0, 0, 1, ir_bad, E_IDLE,  16'h0, 5'h0);

    // Clear at T4 count=2 aborts silently
    add(0, 1, 1, ir_a, E_IDLE, 16'h0, 5'h0);
    add(0, 0, 1, ir_a, E_T0,   16'h0, 5'h0);
    add(0, 0, 1, ir_a, E_T1R,  16'h0, 5'h0);
    add(0, 0, 1, ir_a, E_T2,   16'h0, 5'h0);
    add(0, 0, 1, ir_a, E_T3,   16'h0002, 5'h0);
    add(0, 0, 1, ir_a, E_T4,   16'h0002, OP_DIV);
    add(0, 0, 1, ir_a, E_T4,   16'h0002, OP_DIV);
    add(1, 0, 1, ir_a, E_T4,   16'h0002, OP_DIV);
    add(0, 0, 1, ir_a, E_IDLE, 16'h0, 5'h0);
    add(0, 0, 1, ir_a, E_IDLE, 16'h0, 5'h0);

    // Clear during T1 wait aborts silently
    add(0, 1, 0, ir_a, E_IDLE, 16'h0, 5'h0);
    add(0, 0, 0, ir_a, E_T0,   16'h0, 5'h0);
    add(1, 0, 0, ir_a, E_T1W,  16'h0, 5'h0);
    add(0, 0, 1, ir_a, E_IDLE, 16'h0, 5'h0);

    // start held high across DONE: restart right after IDLE, no overlap
    add(0, 1, 1, ir_b, E_IDLE, 16'h0, 5'h0);
    add(0, 1, 1, ir_b, E_T0,   16'h0, 5'h0);
    add(0, 1, 1, ir_b, E_T1R,  16'h0, 5'h0);
    add(0, 1, 1, ir_b, E_T2,   16'h0, 5'h0);
    add(0, 1, 1, ir_b, E_T3,   16'h0008, 5'h0);
    for (int i = 0; i < 3; i++) add(0, 1, 1, ir_b, E_T4, 16'h0020, OP_DIV);
    add(0, 1, 1, ir_b, E_T4Z,  16'h0020, OP_DIV);
    add(0, 1, 1, ir_b, E_T5,   16'h0, 5'h0);
    add(0, 1, 1, ir_b, E_T6,   16'h0, 5'h0);
    add(0, 1, 1, ir_b, E_DONE, 16'h0, 5'h0);
    add(0, 1, 1, ir_b, E_IDLE, 16'h0, 5'h0);
    add(0, 0, 1, ir_b, E_T0,   16'h0, 5'h0);
    add(0, 0, 1, ir_b, E_T1R,  16'h0, 5'h0);
    add(0, 0, 1, ir_b, E_T2,   16'h0, 5'h0);
    add(0, 0, 1, ir_b, E_T3,   16'h0008, 5'h0);
    for (int i = 0; i < 3; i++) add(0, 0, 1, ir_b, E_T4, 16'h0020, OP_DIV);
    add(0, 0, 1, ir_b, E_T4Z,  16'h0020, OP_DIV);
    add(0, 0, 1, ir_b, E_T5,   16'h0, 5'h0);
    add(0, 0, 1, ir_b, E_T6,   16'h0, 5'h0);
    add(0, 0, 1, ir_b, E_DONE, 16'h0, 5'h0);
    add(0, 0, 1, ir_b, E_IDLE, 16'h0, 5'h0);

    // power-on reset: Clear high for two edges
    Clear = 1'b1; start = 1'b0; mem_ready = 1'b1; IR_q = ir_a;
    @(posedge clk);
    @(posedge clk);

    foreach (tbl[k]) begin
      @(negedge clk);
      Clear     = tbl[k].clr;
      start     = tbl[k].st;
      mem_ready = tbl[k].rdy;
      IR_q      = tbl[k].ir;
      #1;
      total++;
      if (strobes() !== tbl[k].strb) begin
        bad++;
        $display("FAIL row%0d strobes: got %05h want %05h", k, strobes(), tbl[k].strb);
      end
      total++;
      if (Rout !== tbl[k].rout) begin
        bad++;
        $display("FAIL row%0d Rout: got %04h want %04h", k, Rout, tbl[k].rout);
      end
      total++;
      if (IRout !== tbl[k].irout) begin
        bad++;
        $display("FAIL row%0d IRout: got %02h want %02h", k, IRout, tbl[k].irout);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
